fwd_hazard_unit: RTL and testbench
==================================

Name: fwd_hazard_unit

Overview:
Parametrised forwarding and hazard unit for the pipelined RV core. It generalises operand forwarding to NUM_SRC source operands and adds sequential hazard handling. A load-use stall FSM supports a configurable load latency. A register scoreboard tracks long-latency (mul/div) results that are still in flight. It sits beside the ID/EX pipeline registers and drives the EX operand muxes plus the IF/ID stall and ID/EX bubble controls.

Parameters:
NUM_SRC, 2, number of source operands per instruction (2..3)
REG_W, 5, register address width; 2**REG_W architectural registers
LOAD_STALL, 1, stall cycles per load-use hazard (1..7)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
id_rs  in  NUM_SRC*REG_W  decode-stage source addresses, src i at [i*REG_W +: REG_W]
id_rs_used  in  NUM_SRC  per-source "operand actually read" flag
id_rd  in  REG_W  decode-stage destination
id_regwrite  in  1  decode instruction writes id_rd
id_is_md  in  1  decode instruction is long-latency (mul/div)
ex_rs  in  NUM_SRC*REG_W  EX-stage source addresses
ex_imm_sel  in  NUM_SRC  EX source i replaced by immediate (ALUSrc per source)
ex_rd  in  REG_W  EX destination
ex_regwrite  in  1  EX instruction writes ex_rd
ex_memread  in  1  EX instruction is a load
mem_rd  in  REG_W  MEM destination
mem_regwrite  in  1  MEM writes mem_rd
wb_rd  in  REG_W  WB destination
wb_regwrite  in  1  WB writes wb_rd
md_done  in  1  long-latency unit completes, result written back this cycle
md_rd  in  REG_W  destination of completing long-latency op
flush  in  1  kill instruction in ID (branch/jump redirect)
fwd_sel  out  2*NUM_SRC  per-source mux select, src i at [2*i +: 2]
stall  out  1  hold PC and IF/ID
bubble_ex  out  1  load NOP into ID/EX
sb_busy  out  2**REG_W  scoreboard busy vector, bit 0 always 0
md_pending  out  REG_W+1  count of busy scoreboard bits

Behaviour:
- Reset, synchronous, priority over all other inputs: FSM to IDLE, counter to 0, sb_busy to 0, md_pending to 0. While rst=1, stall=0, bubble_ex=0 and fwd_sel=0.
- Forwarding is combinational and evaluated independently per source i:
  - ex_imm_sel[i]=1 -> 2'b11.
  - Else mem_regwrite && mem_rd!=0 && mem_rd==ex_rs[i] -> 2'b01.
  - Else wb_regwrite && wb_rd!=0 && wb_rd==ex_rs[i] -> 2'b10.
  - Else 2'b00 (regfile).
  - MEM has priority over WB.
- Load-use detect (lu_hit): ex_memread && ex_regwrite && ex_rd!=0 && any i with id_rs_used[i] && id_rs[i]==ex_rd.
- Load-use FSM states: IDLE, LU_WAIT; counter cnt is 3 bits.
  - IDLE with lu_hit && !flush: stall=1 this cycle. If LOAD_STALL>1, go to LU_WAIT with cnt=LOAD_STALL-1; else stay in IDLE.
  - LU_WAIT: stall=1 and cnt decrements each cycle. When cnt==1, go to IDLE.
  - Total stall is exactly LOAD_STALL cycles per hazard.
  - lu_hit is not re-evaluated in LU_WAIT.
- Scoreboard stall (sb_hit) asserts on either condition:
  - Any i with id_rs_used[i] && sb_busy[id_rs[i]] (RAW).
  - id_regwrite && id_rd!=0 && sb_busy[id_rd] (WAW).
  - A busy bit cleared by md_done in the same cycle still counts as busy; there is no bypass, and the stall releases next cycle.
- Outputs: stall = (lu_hit in IDLE) | LU_WAIT | sb_hit, all masked to 0 when flush=1. bubble_ex = stall.
- Issue: id_is_md && id_regwrite && id_rd!=0 && !stall && !flush sets sb_busy[id_rd] at the next edge.
- Completion: md_done clears sb_busy[md_rd] at the next edge.
  - md_done on a non-busy register, or md_rd=0, is ignored.
  - Set and clear of the same index in one cycle: set wins.
- md_pending = popcount of sb_busy; registered, updated with sb_busy.
- Flush: FSM forced to IDLE and cnt to 0 at the next edge; stall masked in the same cycle. Scoreboard contents are retained, since in-flight ops still complete.
- x0 is never forwarded, never stalled on, and never marked busy.

Test Plan:
1. NUM_SRC=2: mem_rd=5, wb_rd=5, both regwrite, ex_rs={5,5}, ex_imm_sel=2'b10 -> fwd_sel = src0 01, src1 11. Then mem_regwrite=0 -> src0 10. With ex_rs=0 -> 00.
2. LOAD_STALL=1: ld x7 in EX, id_rs0=7 used -> stall=1 and bubble_ex=1 for exactly 1 cycle. With id_rs_used=0 -> no stall.
3. LOAD_STALL=3: same hazard -> stall high for exactly 3 consecutive cycles, then 0. Flush on cycle 2 -> stall 0 that cycle; FSM IDLE next cycle.
4. Issue mul x9 -> sb_busy[9]=1, md_pending=1. Next instruction reads x9 -> stall held until the cycle after md_done with md_rd=9; then md_pending=0.
5. WAW: x9 busy, decode writes x9 (non-md) -> stall. md_done with md_rd=3 while x3 is not busy -> sb_busy unchanged.
6. Assert rst mid-LU_WAIT with x4 and x9 busy -> next cycle sb_busy=0, md_pending=0, stall=0, FSM IDLE.

Source files
------------

// File: rtl/fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : fwd_hazard_unit
// Purpose  : EX operand forwarding, load-use stall FSM and mul/div scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module fwd_hazard_unit #(
    parameter int NUM_SRC    = 2,
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC*REG_W-1:0]   id_rs,
    input  logic [NUM_SRC-1:0]         id_rs_used,
    input  logic [REG_W-1:0]           id_rd,
    input  logic                       id_regwrite,
    input  logic                       id_is_md,
    input  logic [NUM_SRC*REG_W-1:0]   ex_rs,
    input  logic [NUM_SRC-1:0]         ex_imm_sel,
    input  logic [REG_W-1:0]           ex_rd,
    input  logic                       ex_regwrite,
    input  logic                       ex_memread,
    input  logic [REG_W-1:0]           mem_rd,
    input  logic                       mem_regwrite,
    input  logic [REG_W-1:0]           wb_rd,
    input  logic                       wb_regwrite,
    input  logic                       md_done,
    input  logic [REG_W-1:0]           md_rd,
    input  logic                       flush,
    output logic [2*NUM_SRC-1:0]       fwd_sel,
    output logic                       stall,
    output logic                       bubble_ex,
    output logic [(2**REG_W)-1:0]      sb_busy,
    output logic [REG_W:0]             md_pending
);

    localparam int         NREG      = 2**REG_W;
    localparam logic [2:0] C_LU_INIT = 3'(LOAD_STALL - 1);

    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_LU_WAIT = 1'b1
    } state_t;

    state_t                 state_q;
    logic [2:0]             cnt_q;
    logic [NREG-1:0]        sb_busy_q, sb_busy_d;
    logic [REG_W:0]         md_pending_q, md_pending_d;

    logic [NUM_SRC-1:0]     w_lu_src;
    logic [NUM_SRC-1:0]     w_raw_src;
    logic                   w_lu_hit;
    logic                   w_sb_hit;
    logic                   w_stall;
    logic                   w_issue;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        logic [REG_W-1:0] w_ex_src;
        logic [REG_W-1:0] w_id_src;
        logic [1:0]       w_sel;

        assign w_ex_src = ex_rs[gi*REG_W +: REG_W];
        assign w_id_src = id_rs[gi*REG_W +: REG_W];

        // MEM result is younger than WB, so it wins when both match
        always_comb begin
            w_sel = 2'b00;
            if (ex_imm_sel[gi])
                w_sel = 2'b11;
            else if (mem_regwrite && (mem_rd != '0) && (mem_rd == w_ex_src))
                w_sel = 2'b01;
            else if (wb_regwrite && (wb_rd != '0) && (wb_rd == w_ex_src))
                w_sel = 2'b10;
        end

        assign fwd_sel[2*gi +: 2] = rst ? 2'b00 : w_sel;
        assign w_lu_src[gi]       = id_rs_used[gi] && (w_id_src == ex_rd);
        assign w_raw_src[gi]      = id_rs_used[gi] && sb_busy_q[w_id_src];
    end

    assign w_lu_hit = ex_memread && ex_regwrite && (ex_rd != '0) && (|w_lu_src);
    assign w_sb_hit = (|w_raw_src) ||
                      (id_regwrite && (id_rd != '0) && sb_busy_q[id_rd]);

    assign w_stall  = !rst && !flush &&
                      (((state_q == ST_IDLE) && w_lu_hit) ||
                       (state_q == ST_LU_WAIT) || w_sb_hit);
    assign stall     = w_stall;
    assign bubble_ex = w_stall;

    // Load-use FSM: the IDLE cycle that detects the hazard is the first stall cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state_q <= ST_IDLE;
            cnt_q   <= 3'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_lu_hit && (LOAD_STALL > 1)) begin
                        state_q <= ST_LU_WAIT;
                        cnt_q   <= C_LU_INIT;
                    end
                end
                ST_LU_WAIT: begin
                    if (cnt_q == 3'd1) begin
                        state_q <= ST_IDLE;
                        cnt_q   <= 3'd0;
                    end else begin
                        cnt_q   <= cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= 3'd0;
                end
            endcase
        end
    end

    assign w_issue = id_is_md && id_regwrite && (id_rd != '0) && !w_stall && !flush;

    // Set is applied after clear so a same-index issue wins over completion
    always_comb begin
        sb_busy_d = sb_busy_q;
        if (md_done && (md_rd != '0))
            sb_busy_d[md_rd] = 1'b0;
        if (w_issue)
            sb_busy_d[id_rd] = 1'b1;
        sb_busy_d[0] = 1'b0;
    end

    always_comb begin
        md_pending_d = '0;
        for (int k = 0; k < NREG; k++)
            md_pending_d = md_pending_d + (REG_W+1)'(sb_busy_d[k]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_busy_q    <= '0;
            md_pending_q <= '0;
        end else begin
            sb_busy_q    <= sb_busy_d;
            md_pending_q <= md_pending_d;
        end
    end

    assign sb_busy    = sb_busy_q;
    assign md_pending = md_pending_q;

endmodule
`default_nettype wire

// File: tb/tb_fwd_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwd_hazard_unit
// Purpose  : Scoreboard bench for fwd_hazard_unit against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fwd_hazard_unit;

    localparam int NS   = 2;
    localparam int RW   = 5;
    localparam int LS   = 3;
    localparam int NR   = 32;
    localparam int NCYC = 3000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [NS*RW-1:0]  id_rs;
    logic [NS-1:0]     id_rs_used;
    logic [RW-1:0]     id_rd;
    logic              id_regwrite, id_is_md;
    logic [NS*RW-1:0]  ex_rs;
    logic [NS-1:0]     ex_imm_sel;
    logic [RW-1:0]     ex_rd;
    logic              ex_regwrite, ex_memread;
    logic [RW-1:0]     mem_rd;
    logic              mem_regwrite;
    logic [RW-1:0]     wb_rd;
    logic              wb_regwrite, md_done;
    logic [RW-1:0]     md_rd;
    logic              flush;
    logic [2*NS-1:0]   fwd_sel;
    logic              stall, bubble_ex;
    logic [NR-1:0]     sb_busy;
    logic [RW:0]       md_pending;

    fwd_hazard_unit #(.NUM_SRC(NS), .REG_W(RW), .LOAD_STALL(LS)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rs_used(id_rs_used),
        .id_rd(id_rd), .id_regwrite(id_regwrite), .id_is_md(id_is_md),
        .ex_rs(ex_rs), .ex_imm_sel(ex_imm_sel), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .md_done(md_done), .md_rd(md_rd),
        .flush(flush), .fwd_sel(fwd_sel), .stall(stall),
        .bubble_ex(bubble_ex), .sb_busy(sb_busy), .md_pending(md_pending)
    );

    typedef struct {
        logic             rst;
        logic [NS*RW-1:0] id_rs;
        logic [NS-1:0]    id_rs_used;
        logic [RW-1:0]    id_rd;
        logic             id_regwrite, id_is_md;
        logic [NS*RW-1:0] ex_rs;
        logic [NS-1:0]    ex_imm_sel;
        logic [RW-1:0]    ex_rd;
        logic             ex_regwrite, ex_memread;
        logic [RW-1:0]    mem_rd;
        logic             mem_regwrite;
        logic [RW-1:0]    wb_rd;
        logic             wb_regwrite, md_done;
        logic [RW-1:0]    md_rd;
        logic             flush;
    } stim_t;

    typedef struct {
        int              cyc;
        logic [2*NS-1:0] fwd;
        logic            stall;
        logic [NR-1:0]   busy;
        logic [RW:0]     pend;
    } exp_t;

    exp_t expq[$];
    int   n_total = 0;
    int   n_pass  = 0;
    int   cyc_no  = 0;

    // Reference model: remaining load-use stall cycles and the set of busy registers
    int   lu_left = 0;
    bit   mbusy[NR];

    function automatic stim_t zs();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    function automatic logic [RW-1:0] rreg();
        if ($urandom_range(0, 3) == 0) return RW'($urandom_range(0, NR-1));
        return RW'($urandom_range(0, 6));
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s = zs();
        s.rst          = ($urandom_range(0, 99) == 0);
        s.flush        = ($urandom_range(0, 9) == 0);
        for (int i = 0; i < NS; i++) begin
            s.id_rs[i*RW +: RW] = rreg();
            s.ex_rs[i*RW +: RW] = rreg();
        end
        s.id_rs_used   = NS'($urandom);
        s.ex_imm_sel   = ($urandom_range(0, 3) == 0) ? NS'($urandom) : '0;
        s.id_rd        = rreg();
        s.id_regwrite  = $urandom_range(0, 1) == 1;
        s.id_is_md     = ($urandom_range(0, 3) == 0);
        s.ex_rd        = rreg();
        s.ex_regwrite  = $urandom_range(0, 1) == 1;
        s.ex_memread   = ($urandom_range(0, 2) == 0);
        s.mem_rd       = rreg();
        s.mem_regwrite = $urandom_range(0, 1) == 1;
        s.wb_rd        = rreg();
        s.wb_regwrite  = $urandom_range(0, 1) == 1;
        s.md_done      = ($urandom_range(0, 2) == 0);
        s.md_rd        = rreg();
        return s;
    endfunction

    task automatic apply(input stim_t s);
        rst = s.rst; id_rs = s.id_rs; id_rs_used = s.id_rs_used; id_rd = s.id_rd;
        id_regwrite = s.id_regwrite; id_is_md = s.id_is_md; ex_rs = s.ex_rs;
        ex_imm_sel = s.ex_imm_sel; ex_rd = s.ex_rd; ex_regwrite = s.ex_regwrite;
        ex_memread = s.ex_memread; mem_rd = s.mem_rd; mem_regwrite = s.mem_regwrite;
        wb_rd = s.wb_rd; wb_regwrite = s.wb_regwrite; md_done = s.md_done;
        md_rd = s.md_rd; flush = s.flush;
    endtask

    task automatic step(input stim_t s);
        exp_t        e;
        logic [RW-1:0] r;
        bit          lu, sbh;
        @(posedge clk);
        #1;
        apply(s);
        e.cyc = cyc_no;
        cyc_no++;
        lu  = 0;
        sbh = 0;
        for (int i = 0; i < NS; i++) begin
            r = s.ex_rs[i*RW +: RW];
            if (s.rst)                                           e.fwd[2*i +: 2] = 2'd0;
            else if (s.ex_imm_sel[i])                            e.fwd[2*i +: 2] = 2'd3;
            else if (s.mem_regwrite && s.mem_rd != 0 && s.mem_rd == r) e.fwd[2*i +: 2] = 2'd1;
            else if (s.wb_regwrite && s.wb_rd != 0 && s.wb_rd == r)    e.fwd[2*i +: 2] = 2'd2;
            else                                                 e.fwd[2*i +: 2] = 2'd0;
            r = s.id_rs[i*RW +: RW];
            if (s.id_rs_used[i] && r == s.ex_rd) lu = 1;
            if (s.id_rs_used[i] && mbusy[r])     sbh = 1;
        end
        lu  = lu && s.ex_memread && s.ex_regwrite && (s.ex_rd != 0);
        if (s.id_regwrite && s.id_rd != 0 && mbusy[s.id_rd]) sbh = 1;
        e.stall = !s.rst && !s.flush && ((lu_left > 0) || lu || sbh);
        e.pend  = '0;
        for (int k = 0; k < NR; k++) begin
            e.busy[k] = mbusy[k];
            e.pend    = e.pend + (RW+1)'(mbusy[k]);
        end
        expq.push_back(e);

        if (s.rst) begin
            lu_left = 0;
            for (int k = 0; k < NR; k++) mbusy[k] = 0;
        end else begin
            if (s.flush)          lu_left = 0;
            else if (lu_left > 0) lu_left = lu_left - 1;
            else if (lu)          lu_left = LS - 1;
            if (s.md_done && s.md_rd != 0) mbusy[s.md_rd] = 0;
            if (s.id_is_md && s.id_regwrite && s.id_rd != 0 && !e.stall && !s.flush)
                mbusy[s.id_rd] = 1;
        end
    endtask

    task automatic chk(input string nm, input int cyc, input logic [63:0] act,
                       input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s cycle=%0d actual=%h required=%h", nm, cyc, act, req);
    endtask

    always @(negedge clk) begin
        if (expq.size() > 0) begin
            exp_t e;
            e = expq.pop_front();
            chk("fwd_sel",    e.cyc, 64'(fwd_sel),    64'(e.fwd));
            chk("stall",      e.cyc, 64'(stall),      64'(e.stall));
            chk("bubble_ex",  e.cyc, 64'(bubble_ex),  64'(e.stall));
            chk("sb_busy",    e.cyc, 64'(sb_busy),    64'(e.busy));
            chk("md_pending", e.cyc, 64'(md_pending), 64'(e.pend));
        end
    end

    initial begin
        stim_t s;
        s = zs();
        s.rst = 1'b1;
        apply(s);
        step(s);

        // Forwarding priority and immediate override
        s = zs();
        s.mem_rd = 5; s.mem_regwrite = 1; s.wb_rd = 5; s.wb_regwrite = 1;
        s.ex_rs = {5'd5, 5'd5}; s.ex_imm_sel = 2'b10;
        step(s);
        s.mem_regwrite = 0;
        step(s);
        s.ex_rs = '0;
        step(s);

        // Load-use hazard, then the same operands unused
        s = zs();
        s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 7;
        s.id_rs = {5'd0, 5'd7}; s.id_rs_used = 2'b01;
        step(s);
        repeat (4) step(zs());
        s.id_rs_used = 2'b00;
        step(s);
        s.id_rs_used = 2'b01;
        step(s);
        s = zs(); s.flush = 1;
        step(s);
        repeat (3) step(zs());

        // Scoreboard RAW hold until the cycle after md_done
        s = zs(); s.id_is_md = 1; s.id_regwrite = 1; s.id_rd = 9;
        step(s);
        s = zs(); s.id_rs = {5'd0, 5'd9}; s.id_rs_used = 2'b01;
        repeat (3) step(s);
        s.md_done = 1; s.md_rd = 9;
        step(s);
        s.md_done = 0;
        repeat (2) step(s);

        // WAW stall and completion of a non-busy register
        s = zs(); s.id_is_md = 1; s.id_regwrite = 1; s.id_rd = 9;
        step(s);
        s = zs(); s.id_regwrite = 1; s.id_rd = 9;
        step(s);
        s = zs(); s.md_done = 1; s.md_rd = 3;
        step(s);
        s.md_rd = 9;
        step(s);

        // Reset in the middle of a load-use wait with busy registers
        s = zs(); s.id_is_md = 1; s.id_regwrite = 1; s.id_rd = 4;
        step(s);
        s.id_rd = 9;
        step(s);
        s = zs();
        s.ex_memread = 1; s.ex_regwrite = 1; s.ex_rd = 6;
        s.id_rs = {5'd6, 5'd0}; s.id_rs_used = 2'b10;
        step(s);
        step(zs());
        s = zs(); s.rst = 1;
        step(s);
        repeat (2) step(zs());

        for (int n = 0; n < NCYC; n++) step(rnd());

        repeat (3) @(negedge clk);
        if (expq.size() != 0) begin
            n_total++;
            $display("FAIL drain pending=%0d required=0", expq.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
